reg_write_scheduler: RTL and testbench
======================================

Name: reg_write_scheduler

Overview:
Write-side front end for the register bank. It accepts write requests (address, data) over a valid/ready handshake and buffers them in a small in-order queue. It drains one entry per cycle into the bank through registered WE/WA/WD strobes. A combinational read-forwarding port returns the newest pending value for an address, so readers never see stale data while writes are still queued.

Parameters:
M, 32, data width of each register
N_REGS, 16, number of registers in the bank
ADDR_W, 4, address width; must equal $clog2(N_REGS)
DEPTH, 4, queue entries; power of two, at least 2
ZERO_REG, 1, 1 = writes to address 0 are accepted but discarded (never enqueued)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low
req_valid  in  1  write request present
req_ready  out  1  queue can accept a request this cycle
req_addr  in  ADDR_W  target register
req_data  in  M  write data
stall  in  1  1 = hold the drain; no pop this cycle
WE  out  1  write-enable strobe to the bank, registered
WA  out  ADDR_W  write address to the bank, registered
WD  out  M  write data to the bank, registered
rd_addr  in  ADDR_W  forwarding lookup address
rd_data_in  in  M  bank's current read value for rd_addr
rd_data  out  M  forwarded read value
level  out  $clog2(DEPTH)+1  number of queued entries, excluding the output stage
busy  out  1  level != 0 or WE == 1

Behaviour:
- Reset (reset = 0, asynchronous):
  - Queue is emptied; head and tail pointers = 0; level = 0.
  - WE = 0, WA = 0, WD = 0, busy = 0.
  - Pending writes are lost, including when reset is asserted mid-drain.
- Handshake:
  - req_ready = (level != DEPTH); it is combinational from state only and never depends on req_valid.
  - A push occurs on a rising edge where req_valid = 1 and req_ready = 1.
  - While req_valid = 0, req_addr and req_data are ignored.
- ZERO_REG:
  - With ZERO_REG = 1, a handshake with req_addr = 0 completes (ready still governs it), but nothing is enqueued.
- Drain:
  - On each rising edge, if level != 0 and stall = 0, the head entry is popped into the WA/WD registers and WE <= 1.
  - Otherwise WE <= 0, and WA/WD hold their previous values.
  - WE is therefore a one-cycle pulse per entry; back-to-back entries give continuous WE = 1.
- Latency: a request accepted at edge k into an empty queue, with stall = 0, has WE = 1 during the cycle after edge k+1. That is 2 edges, with no bypass.
- Simultaneous push and pop: both take effect on the same edge and level is unchanged.
  - Because req_ready uses the pre-edge level, a full queue refuses a push even if a pop happens that edge.
- Pointers are ADDR-of-queue width $clog2(DEPTH) and wrap modulo DEPTH. Full and empty are distinguished by level, not by pointer equality.
- Ordering: strictly FIFO, including multiple writes to the same address. The last write wins in the bank.
- Forwarding (combinational), for rd_data:
  - Priority 1: the youngest queued entry with addr == rd_addr.
  - Priority 2: else, the output stage, if WE = 1 and WA == rd_addr.
  - Priority 3: else, rd_data_in.
  - With ZERO_REG = 1 and rd_addr = 0, rd_data = 0.
- A request being pushed in the current cycle is not forwarded until after the edge.
- stall has no effect on req_ready, push, or forwarding.

Decomposition:
- Package reg_sched_pkg holds:
  - typedef wr_req_t, a packed struct {addr, data}.
  - The default constants M, N_REGS, DEPTH.
  - A helper function for level width.
- One natural sub-module: sync_fifo (parameterised on width and DEPTH, with push, pop, full, empty, count and exposed storage for the forwarding search). It is instantiated once with wr_req_t.
- The forwarding priority search stays in the top level as an always_comb loop from oldest to youngest.

Test Plan:
- Reset then idle: hold reset = 0 for 3 cycles, then release -> WE = 0, level = 0, req_ready = 1, busy = 0.
- Single write: push addr 3, data 0xDEADBEEF at edge k -> WE = 1, WA = 3, WD = 0xDEADBEEF only in the cycle after edge k+1. Before that edge, rd_addr = 3 gives rd_data = 0xDEADBEEF while rd_data_in = 0.
- Fill and backpressure: with stall = 1, push 4 writes (addr 1..4, data 0x11..0x44) -> level = 4 and req_ready = 0. A 5th valid request is held and not accepted. Drop stall -> WE pulses for 4 consecutive cycles with addr 1,2,3,4 in order, then the 5th request enters.
- Same-address ordering and forwarding: stall = 1; push addr 5 = 0xA, then addr 5 = 0xB -> rd_data for addr 5 = 0xB. After the drain, WD sequence is 0xA, 0xB.
- Zero register: push addr 0, data 0xFFFF -> handshake completes, level stays 0, no WE pulse, and rd_data for addr 0 = 0.
- Reset mid-drain: queue 3 entries, assert reset after the first WE pulse -> WE = 0 immediately (asynchronous), level = 0. After release there are no further WE pulses.

Source files
------------

// File: rtl/reg_sched_pkg.sv
// Shared types and defaults for the register-bank write scheduler.
//   DEF_M / DEF_N_REGS / DEF_DEPTH : default data width, bank size, queue depth
//   wr_req_t                       : one queued write (addr, data)
//   level_w()                      : width of an occupancy counter for a given depth
package reg_sched_pkg;

  localparam int DEF_M      = 32;
  localparam int DEF_N_REGS = 16;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ADDR_W = $clog2(DEF_N_REGS);

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_M-1:0]      data;
  } wr_req_t;

  // Occupancy must represent 0..depth inclusive, hence one extra bit.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_write_scheduler_if.sv
// Write-request channel into the scheduler (valid/ready handshake).
//   req_valid : request present (master -> slave)
//   req_ready : slave can take a request this cycle (slave -> master)
//   req_addr  : target register
//   req_data  : write data
interface reg_write_scheduler_if #(
  parameter int ADDR_W = reg_sched_pkg::DEF_ADDR_W,
  parameter int M      = reg_sched_pkg::DEF_M
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [M-1:0]      req_data;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/sync_fifo.sv
// In-order queue with its storage exposed for associative lookups.
//   clk, reset       : clock, asynchronous active-low reset
//   i_push / i_wdata : enqueue (ignored when full)
//   i_pop / o_rdata  : dequeue head (ignored when empty); o_rdata is the head
//   o_full/o_empty   : derived from the occupancy count, not pointer equality
//   o_count          : occupancy
//   o_head / o_mem   : head pointer and raw storage for the forwarding search
module sync_fifo
  import reg_sched_pkg::*;
#(
  parameter type T      = wr_req_t,
  parameter int  DEPTH  = DEF_DEPTH,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = level_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  T              i_wdata,
  output T              o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic [PW-1:0] o_head,
  output T              o_mem [DEPTH]
);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_wdata;
  end

  assign o_rdata = r_mem[r_head];
  assign o_count = r_count;
  assign o_head  = r_head;
  assign o_mem   = r_mem;

endmodule

// File: rtl/reg_write_scheduler.sv
// Write-side front end for the register bank: buffers write requests in an
// in-order queue, drains one per cycle into registered WE/WA/WD strobes and
// forwards the newest pending value for a read address.
//   clk, reset      : clock, asynchronous active-low reset
//   req             : write-request channel (slave side)
//   stall           : hold the drain this cycle
//   WE, WA, WD      : registered bank write port
//   rd_addr         : forwarding lookup address
//   rd_data_in      : bank's current value for rd_addr
//   rd_data         : forwarded read value
//   level, busy     : queue occupancy; activity indicator
module reg_write_scheduler
  import reg_sched_pkg::*;
#(
  parameter int  M        = DEF_M,
  parameter int  N_REGS   = DEF_N_REGS,
  parameter int  ADDR_W   = $clog2(N_REGS),
  parameter int  DEPTH    = DEF_DEPTH,
  parameter int  ZERO_REG = 1,
  localparam int PW       = $clog2(DEPTH),
  localparam int LW       = level_w(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  reg_write_scheduler_if.slave req,
  input  logic                stall,
  output logic                WE,
  output logic [ADDR_W-1:0]   WA,
  output logic [M-1:0]        WD,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [M-1:0]        rd_data_in,
  output logic [M-1:0]        rd_data,
  output logic [LW-1:0]       level,
  output logic                busy
);

  logic          r_we;
  logic [ADDR_W-1:0] r_wa;
  logic [M-1:0]  r_wd;

  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_count;
  logic [PW-1:0] w_head;
  wr_req_t       w_mem [DEPTH];
  wr_req_t       w_wdata;
  wr_req_t       w_rdata;
  logic          w_ready;
  logic          w_zero_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_fwd_hit;
  logic [M-1:0]  w_fwd_data;
  logic [PW-1:0] w_idx;

  // Ready looks only at occupancy before the edge, so a full queue refuses
  // a push even when a pop happens on the same edge.
  assign w_ready       = !w_full;
  assign req.req_ready = w_ready;

  // Writes to register 0 complete the handshake but are dropped here.
  assign w_zero_drop = (ZERO_REG != 0) && (req.req_addr == '0);
  assign w_push      = req.req_valid && w_ready && !w_zero_drop;
  assign w_pop       = !w_empty && !stall;
  assign w_wdata     = {req.req_addr, req.req_data};

  sync_fifo #(
    .T     (wr_req_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head),
    .o_mem   (w_mem)
  );

  // Output stage: head entry -> bank strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we <= 1'b0;
      r_wa <= '0;
      r_wd <= '0;
    end else begin
      r_we <= w_pop;
      if (w_pop) begin
        r_wa <= w_rdata.addr;
        r_wd <= w_rdata.data;
      end
    end
  end

  assign WE    = r_we;
  assign WA    = r_wa;
  assign WD    = r_wd;
  assign level = w_count;
  assign busy  = (w_count != '0) || r_we;

  // Walk from oldest to youngest so the last match is the newest write.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = w_head + PW'(i);
      if ((LW'(i) < w_count) && (w_mem[w_idx].addr == rd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = w_mem[w_idx].data;
      end
    end
  end

  always_comb begin
    if ((ZERO_REG != 0) && (rd_addr == '0))   rd_data = '0;
    else if (w_fwd_hit)                        rd_data = w_fwd_data;
    else if (r_we && (r_wa == rd_addr))        rd_data = r_wd;
    else                                       rd_data = rd_data_in;
  end

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Self-checking bench for reg_write_scheduler: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_reg_write_scheduler;
  import reg_sched_pkg::*;

  localparam int M     = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall;
  logic          WE;
  logic [AW-1:0] WA;
  logic [M-1:0]  WD;
  logic [AW-1:0] rd_addr;
  logic [M-1:0]  rd_data_in;
  logic [M-1:0]  rd_data;
  logic [LW-1:0] level;
  logic          busy;

  always #5 clk = ~clk;

  reg_write_scheduler_if #(.ADDR_W(AW), .M(M)) req_if ();

  reg_write_scheduler #(
    .M(M), .N_REGS(16), .ADDR_W(AW), .DEPTH(DEPTH), .ZERO_REG(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req_if.slave),
    .stall      (stall),
    .WE         (WE),
    .WA         (WA),
    .WD         (WD),
    .rd_addr    (rd_addr),
    .rd_data_in (rd_data_in),
    .rd_data    (rd_data),
    .level      (level),
    .busy       (busy)
  );

  // Reference model: pending writes as a plain queue plus the bank strobes.
  typedef struct {
    logic [AW-1:0] a;
    logic [M-1:0]  d;
  } ent_t;

  ent_t          mq[$];
  logic          m_we;
  logic [AW-1:0] m_wa;
  logic [M-1:0]  m_wd;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  // Newest pending write wins, then the write in flight, then the bank.
  function automatic logic [M-1:0] exp_rd();
    if (rd_addr == '0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == rd_addr) return mq[i].d;
    if (m_we && (m_wa == rd_addr)) return m_wd;
    return rd_data_in;
  endfunction

  task automatic model_edge();
    logic do_pop;
    logic do_push;
    ent_t e;
    if (!reset) begin
      model_reset();
    end else begin
      do_pop  = (mq.size() != 0) && !stall;
      do_push = req_if.req_valid && (mq.size() != DEPTH) && (req_if.req_addr != '0);
      if (do_pop) begin
        m_we = 1'b1;
        m_wa = mq[0].a;
        m_wd = mq[0].d;
        void'(mq.pop_front());
      end else begin
        m_we = 1'b0;
      end
      if (do_push) begin
        e.a = req_if.req_addr;
        e.d = req_if.req_data;
        mq.push_back(e);
      end
    end
  endtask

  task automatic check_all();
    chk("req_ready", 64'(req_if.req_ready), 64'(mq.size() != DEPTH));
    chk("level",     64'(level),            64'(mq.size()));
    chk("busy",      64'(busy),             64'((mq.size() != 0) || m_we));
    chk("WE",        64'(WE),               64'(m_we));
    chk("WA",        64'(WA),               64'(m_wa));
    chk("WD",        64'(WD),               64'(m_wd));
    chk("rd_data",   64'(rd_data),          64'(exp_rd()));
  endtask

  // Inputs are stable from #1 after one rising edge to the next.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [M-1:0] d);
    req_if.req_valid = v;
    req_if.req_addr  = a;
    req_if.req_data  = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, '0, '0);
    stall      = 1'b0;
    rd_addr    = '0;
    rd_data_in = '0;
    reset      = 1'b0;
    model_reset();

    // Reset then idle
    repeat (3) tick();
    reset = 1'b1;
    chk("rst_we",    64'(WE), 64'(0));
    chk("rst_level", 64'(level), 64'(0));
    chk("rst_ready", 64'(req_if.req_ready), 64'(1));
    chk("rst_busy",  64'(busy), 64'(0));
    tick();

    // Single write: strobe appears only after the second edge
    drive(1'b1, 4'd3, 32'hDEADBEEF);
    rd_addr    = 4'd3;
    rd_data_in = '0;
    tick();
    drive(1'b0, '0, '0);
    chk("single_we_early", 64'(WE), 64'(0));
    chk("single_fwd",      64'(rd_data), 64'h0000_0000_DEAD_BEEF);
    tick();
    chk("single_we", 64'(WE), 64'(1));
    chk("single_wa", 64'(WA), 64'(3));
    chk("single_wd", 64'(WD), 64'h0000_0000_DEAD_BEEF);
    repeat (2) tick();

    // Fill under stall, fifth request is held
    stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, AW'(i), M'(i * 32'h11));
      rd_addr = AW'(i);
      tick();
    end
    drive(1'b1, 4'd6, 32'h55);
    tick();
    chk("full_level", 64'(level), 64'(4));
    chk("full_ready", 64'(req_if.req_ready), 64'(0));
    tick();
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) drive(1'b0, '0, '0);
      chk($sformatf("drain_we%0d", i), 64'(WE), 64'(1));
      chk($sformatf("drain_wa%0d", i), 64'(WA), 64'(i + 1));
    end
    repeat (3) tick();

    // Same-address ordering and forwarding
    stall = 1'b1;
    drive(1'b1, 4'd5, 32'hA);
    tick();
    drive(1'b1, 4'd5, 32'hB);
    tick();
    drive(1'b0, '0, '0);
    rd_addr    = 4'd5;
    rd_data_in = 32'h1357_9BDF;
    #1;
    chk("same_fwd", 64'(rd_data), 64'hB);
    stall = 1'b0;
    tick();
    chk("same_wd0", 64'(WD), 64'hA);
    tick();
    chk("same_wd1", 64'(WD), 64'hB);
    tick();

    // Zero register is accepted and discarded
    drive(1'b1, 4'd0, 32'hFFFF);
    rd_addr    = 4'd0;
    rd_data_in = 32'h1234;
    tick();
    drive(1'b0, '0, '0);
    chk("zero_level", 64'(level), 64'(0));
    chk("zero_rd",    64'(rd_data), 64'(0));
    tick();
    chk("zero_no_we", 64'(WE), 64'(0));

    // Reset while draining
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(7 + i), M'(32'h700 + i));
      tick();
    end
    drive(1'b0, '0, '0);
    stall = 1'b0;
    tick();
    chk("md_we", 64'(WE), 64'(1));
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("md_we_async", 64'(WE), 64'(0));
    chk("md_level",    64'(level), 64'(0));
    repeat (2) tick();
    reset = 1'b1;
    repeat (5) tick();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 99) < 60, AW'($urandom_range(0, 5)), M'($urandom));
      stall      = $urandom_range(0, 99) < 30;
      rd_addr    = AW'($urandom_range(0, 5));
      rd_data_in = M'($urandom);
      if (i == 250) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      tick();
    end
    drive(1'b0, '0, '0);
    stall = 1'b0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
